// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ID/EX pipeline register layout.
package riscv_pkg;
    localparam int XLEN_C       = 32;
    localparam int REG_ADDR_W_C = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic       aluSrc;
        logic [1:0] resultSrc;
        logic [2:0] aluControl;
    } ctrlT;

    typedef struct packed {
        ctrlT                    ctrl;
        logic [XLEN_C-1:0]       rd1;
        logic [XLEN_C-1:0]       rd2;
        logic [XLEN_C-1:0]       immExt;
        logic [REG_ADDR_W_C-1:0] rs1;
        logic [REG_ADDR_W_C-1:0] rs2;
        logic [REG_ADDR_W_C-1:0] rd;
        logic [XLEN_C-1:0]       currentPc;
        logic [XLEN_C-1:0]       nextPc;
    } idExT;
endpackage

// File: rtl/register_file.sv
// 2R1W register file: x0 hardwired to zero, async clear, write-through bypass.
module register_file #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [XLEN-1:0]       wd,
    output logic [XLEN-1:0]       rd1,
    output logic [XLEN-1:0]       rd2
);
    localparam int NREGS = 1 << REG_ADDR_W;

    logic [XLEN-1:0] mem [NREGS];
    logic            wrEn;

    assign wrEn = we && !rst && (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (wrEn) begin
            mem[wa] <= wd;
        end
    end

    // Bypass lets a write-back and a dependent decode share one cycle.
    assign rd1 = (ra1 == '0) ? '0 : (wrEn && wa == ra1) ? wd : mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (wrEn && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extension, operand read, ID/EX register.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       InstrD,
    input  logic [XLEN-1:0]       CurrentPCD,
    input  logic [XLEN-1:0]       NextPCD,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RDW,
    input  logic [XLEN-1:0]       ResultW,
    input  logic                  FlushE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic                  ALUSrcE,
    output logic [1:0]            ResultSrcE,
    output logic [2:0]            ALUControlE,
    output logic [XLEN-1:0]       RD1E,
    output logic [XLEN-1:0]       RD2E,
    output logic [XLEN-1:0]       ImmExtE,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [XLEN-1:0]       CurrentPCE,
    output logic [XLEN-1:0]       NextPCE
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [2:0]      immSel;
    logic            aluDecode;
    ctrlT            ctrl;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    idExT            idExNext;
    idExT            idEx;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];

    always_comb begin
        ctrl      = '0;
        immSel    = IMM_NONE;
        aluDecode = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.regWrite = 1'b1;
                aluDecode     = 1'b1;
            end
            OP_I: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                aluDecode     = 1'b1;
                immSel        = IMM_I;
            end
            OP_LW: begin
                ctrl.regWrite  = 1'b1;
                ctrl.resultSrc = RES_MEM;
                ctrl.aluSrc    = 1'b1;
                immSel         = IMM_I;
            end
            OP_SW: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                immSel        = IMM_S;
            end
            OP_BEQ: begin
                ctrl.branch     = 1'b1;
                ctrl.aluControl = ALU_SUB;
                immSel          = IMM_B;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.resultSrc = RES_PC4;
                immSel         = IMM_J;
            end
            default: ;
        endcase

        // funct7[5] only selects sub for R-type; in I-type it is immediate data.
        if (aluDecode) begin
            case (funct3)
                3'b000:  ctrl.aluControl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  ctrl.aluControl = ALU_SLT;
                3'b110:  ctrl.aluControl = ALU_OR;
                3'b111:  ctrl.aluControl = ALU_AND;
                default: ctrl.aluControl = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        case (immSel)
            IMM_I:   immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S:   immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   immExt = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                               InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   immExt = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                               InstrD[20], InstrD[30:21], 1'b0};
            default: immExt = '0;
        endcase
    end

    register_file #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) uRegFile (
        .clk (clk),
        .rst (rst),
        .ra1 (InstrD[19:15]),
        .ra2 (InstrD[24:20]),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    always_comb begin
        idExNext           = '0;
        idExNext.ctrl      = ctrl;
        idExNext.rd1       = rd1;
        idExNext.rd2       = rd2;
        idExNext.immExt    = immExt;
        idExNext.rs1       = InstrD[19:15];
        idExNext.rs2       = InstrD[24:20];
        idExNext.rd        = InstrD[11:7];
        idExNext.currentPc = CurrentPCD;
        idExNext.nextPc    = NextPCD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idEx <= '0;
        end else if (FlushE) begin
            idEx <= '0;
        end else begin
            idEx <= idExNext;
        end
    end

    assign RegWriteE   = idEx.ctrl.regWrite;
    assign MemWriteE   = idEx.ctrl.memWrite;
    assign BranchE     = idEx.ctrl.branch;
    assign JumpE       = idEx.ctrl.jump;
    assign ALUSrcE     = idEx.ctrl.aluSrc;
    assign ResultSrcE  = idEx.ctrl.resultSrc;
    assign ALUControlE = idEx.ctrl.aluControl;
    assign RD1E        = idEx.rd1;
    assign RD2E        = idEx.rd2;
    assign ImmExtE     = idEx.immExt;
    assign Rs1E        = idEx.rs1;
    assign Rs2E        = idEx.rs2;
    assign RdE         = idEx.rd;
    assign CurrentPCE  = idEx.currentPc;
    assign NextPCE     = idEx.nextPc;
endmodule

// File: tb/tb_decode_cycle.sv
// Directed and randomized check of decode_cycle against an instruction-level reference model.
module tb_decode_cycle;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, CurrentPCD, NextPCD, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, CurrentPCE, NextPCE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int nVec = 0;
    int nErr = 0;

    typedef struct {
        logic [31:0] regWrite, memWrite, branch, jump, aluSrc, resultSrc, aluCtl;
        logic [31:0] rd1, rd2, imm, rs1, rs2, rd, pc, npc;
    } expT;

    logic [31:0] regs [32];

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .CurrentPCD(CurrentPCD), .NextPCD(NextPCD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .CurrentPCE(CurrentPCE), .NextPCE(NextPCE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Immediate value from field arithmetic; negative formats wrap via int subtraction.
    function automatic logic [31:0] immOf(input logic [31:0] i, input int fmt);
        int v;
        int neg;
        neg = int'(i >> 31);
        case (fmt)
            1: v = int'(i >> 20) - neg * 4096;
            2: v = int'(((i >> 25) << 5) | ((i >> 7) & 31)) - neg * 4096;
            3: v = int'((((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1))
                   - neg * 4096;
            4: v = int'((((i >> 12) & 255) << 12) | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1))
                   - neg * 1048576;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] readReg(input int a, input logic we, input int wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return regs[a];
    endfunction

    function automatic expT model(input logic [31:0] i, input logic [31:0] pc, input logic we,
                                  input int wa, input logic [31:0] wd, input logic flush);
        expT e;
        int op, f3, rs1, rs2;
        op  = int'(i & 32'h7f);
        f3  = int'((i >> 12) & 7);
        rs1 = int'((i >> 15) & 31);
        rs2 = int'((i >> 20) & 31);
        e = '{default: 32'd0};
        if (flush) return e;
        e.rs1 = 32'(rs1);
        e.rs2 = 32'(rs2);
        e.rd  = (i >> 7) & 31;
        e.pc  = pc;
        e.npc = pc + 4;
        e.rd1 = readReg(rs1, we, wa, wd);
        e.rd2 = readReg(rs2, we, wa, wd);
        case (op)
            'h33, 'h13: begin
                e.regWrite = 1;
                e.aluSrc   = (op == 'h13) ? 1 : 0;
                e.imm      = (op == 'h13) ? immOf(i, 1) : 0;
                if (f3 == 2)      e.aluCtl = 5;
                else if (f3 == 6) e.aluCtl = 3;
                else if (f3 == 7) e.aluCtl = 2;
                else if (f3 == 0 && op == 'h33 && ((i >> 30) & 1) == 1) e.aluCtl = 1;
            end
            'h03: begin e.regWrite = 1; e.resultSrc = 1; e.aluSrc = 1; e.imm = immOf(i, 1); end
            'h23: begin e.memWrite = 1; e.aluSrc = 1; e.imm = immOf(i, 2); end
            'h63: begin e.branch = 1; e.aluCtl = 1; e.imm = immOf(i, 3); end
            'h6f: begin e.jump = 1; e.regWrite = 1; e.resultSrc = 2; e.imm = immOf(i, 4); end
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkAll(input string tag, input expT e);
        chk({tag, ".RegWriteE"},   32'(RegWriteE),   e.regWrite);
        chk({tag, ".MemWriteE"},   32'(MemWriteE),   e.memWrite);
        chk({tag, ".BranchE"},     32'(BranchE),     e.branch);
        chk({tag, ".JumpE"},       32'(JumpE),       e.jump);
        chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     e.aluSrc);
        chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  e.resultSrc);
        chk({tag, ".ALUControlE"}, 32'(ALUControlE), e.aluCtl);
        chk({tag, ".RD1E"},        RD1E,             e.rd1);
        chk({tag, ".RD2E"},        RD2E,             e.rd2);
        chk({tag, ".ImmExtE"},     ImmExtE,          e.imm);
        chk({tag, ".Rs1E"},        32'(Rs1E),        e.rs1);
        chk({tag, ".Rs2E"},        32'(Rs2E),        e.rs2);
        chk({tag, ".RdE"},         32'(RdE),         e.rd);
        chk({tag, ".CurrentPCE"},  CurrentPCE,       e.pc);
        chk({tag, ".NextPCE"},     NextPCE,          e.npc);
    endtask

    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic flush);
        expT e;
        @(negedge clk);
        InstrD = instr; CurrentPCD = pc; NextPCD = pc + 4;
        RegWriteW = we; RDW = wa; ResultW = wd; FlushE = flush;
        e = model(instr, pc, we, int'(wa), wd, flush);
        @(posedge clk);
        if (we && wa != 0) regs[wa] = wd;
        #1;
        checkAll(tag, e);
    endtask

    initial begin
        expT zero;
        logic [31:0] r, pc;
        logic [6:0]  ops [7];
        zero = '{default: 32'd0};
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h7f};
        for (int k = 0; k < 32; k++) regs[k] = 32'd0;

        rst = 1'b1; InstrD = 32'h00500093; CurrentPCD = 32'h100; NextPCD = 32'h104;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0; FlushE = 1'b0;
        #12;
        checkAll("reset", zero);
        @(negedge clk); rst = 1'b0;

        step("addi", 32'h00500093, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0);
        step("bypass", 32'h00018233, 32'h104, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        step("bypass_held", 32'h00018233, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0);
        step("x0_write", 32'h000002B3, 32'h10c, 1'b1, 5'd0, 32'h1234, 1'b0);
        step("x0_read", 32'h000002B3, 32'h110, 1'b0, 5'd0, 32'd0, 1'b0);
        step("beq_neg", 32'hFE208CE3, 32'h114, 1'b0, 5'd0, 32'd0, 1'b0);
        step("sub", 32'h40218233, 32'h118, 1'b1, 5'd2, 32'h00000042, 1'b0);
        step("flush_lw", 32'h0001A303, 32'h11c, 1'b1, 5'd7, 32'h000055AA, 1'b1);
        step("after_flush", 32'h00038433, 32'h120, 1'b0, 5'd0, 32'd0, 1'b0);

        // Asynchronous reset between edges, then confirm the file was cleared.
        #3 rst = 1'b1;
        #1 checkAll("reset_mid", zero);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) regs[k] = 32'd0;
        step("post_reset", 32'h0071C433, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            r  = $urandom();
            pc = $urandom() & 32'hFFFFFFFC;
            step("rand", {r[31:7], ops[$urandom_range(0, 6)]}, pc, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
